// File: rtl/dcache_mshr_if.sv
// Signal bundle between the MSHR and its surroundings: the load/store requester,
// the memory bus and the fill path back into the Dcache.
interface dcache_mshr_if;
   // Requester side
   logic        ld_miss_en;
   logic [63:0] ld_miss_addr;
   logic        st_en;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   // Memory bus
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   // Fill path and handshakes
   logic [63:0] mshr_addr;
   logic [63:0] mshr_data;
   logic        mshr_vld;
   logic        mshr_ld_ack;
   logic        mshr_st_ack;
   logic        mshr_stall;

   // master: the requester plus memory environment; slave: the MSHR itself
   modport master (
      output ld_miss_en, ld_miss_addr, st_en, st_addr, st_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mshr_addr, mshr_data, mshr_vld, mshr_ld_ack, mshr_st_ack, mshr_stall
   );

   modport slave (
      input  ld_miss_en, ld_miss_addr, st_en, st_addr, st_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output mshr_addr, mshr_data, mshr_vld, mshr_ld_ack, mshr_st_ack, mshr_stall
   );
endinterface

// File: rtl/dcache_mshr.sv
// Miss-status holding registers: queue load misses and write-through stores,
// issue them to memory in allocation order and return tagged load fills.
module dcache_mshr #(
   parameter int MSHR_DEPTH = 4,
   parameter int MSHR_IDX_W = 2
) (
   input logic           clk,
   input logic           rst,
   dcache_mshr_if.slave  bus
);

   typedef enum logic [1:0] {
      E_FREE       = 2'd0,
      E_WAIT_ISSUE = 2'd1,
      E_WAIT_MEM   = 2'd2
   } ent_state_e;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef logic [MSHR_IDX_W-1:0] idx_t;
   typedef logic [MSHR_IDX_W:0]   ptr_t;

   ent_state_e  state_q [MSHR_DEPTH];
   ent_state_e  state_d [MSHR_DEPTH];
   logic        is_st_q [MSHR_DEPTH];
   logic [3:0]  tag_q   [MSHR_DEPTH];
   logic [60:0] blk_q   [MSHR_DEPTH];
   logic [63:0] data_q  [MSHR_DEPTH];

   // Issue order FIFO; pointers carry one extra MSB so full and empty differ
   idx_t fifo_q [MSHR_DEPTH];
   ptr_t wr_ptr_q, rd_ptr_q;

   logic        vld_q, ld_ack_q, st_ack_q;
   logic [63:0] fill_addr_q, fill_data_q;

   ptr_t        free_cnt;
   logic        have_first, have_second;
   idx_t        first_free, second_free;
   logic        merge_hit;
   logic        st_alloc, ld_alloc;
   idx_t        ld_idx;
   ptr_t        ld_slot;
   logic        fifo_empty;
   idx_t        head_idx;
   logic        issue_fire;
   logic        ret_hit;
   idx_t        ret_idx;
   logic [60:0] ld_blk;

   logic unused_low_bits;
   assign unused_low_bits = ^{bus.ld_miss_addr[2:0], bus.st_addr[2:0]};

   assign ld_blk     = bus.ld_miss_addr[63:3];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign head_idx   = fifo_q[rd_ptr_q[MSHR_IDX_W-1:0]];
   assign issue_fire = !fifo_empty && (bus.mem2proc_response != 4'd0);

   // Free-entry scan, merge lookup and return-tag match
   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      free_cnt    = '0;
      have_first  = 1'b0;
      have_second = 1'b0;
      first_free  = '0;
      second_free = '0;
      merge_hit   = 1'b0;
      ret_hit     = 1'b0;
      ret_idx     = '0;
      for (int i = 0; i < MSHR_DEPTH; i++) begin
         if (state_q[i] == E_FREE) begin
            free_cnt = free_cnt + ptr_t'(1);
            if (!have_first) begin
               have_first = 1'b1;
               first_free = idx_t'(i);
            end else if (!have_second) begin
               have_second = 1'b1;
               second_free = idx_t'(i);
            end
         end
         if (state_q[i] != E_FREE && !is_st_q[i] && blk_q[i] == ld_blk)
            merge_hit = 1'b1;
         if (!ret_hit && state_q[i] == E_WAIT_MEM && bus.mem2proc_tag != 4'd0 &&
             tag_q[i] == bus.mem2proc_tag) begin
            ret_hit = 1'b1;
            ret_idx = idx_t'(i);
         end
      end
   end

   // Store is the older request, so it takes the lowest free entry
   always_comb begin
      st_alloc = bus.st_en && have_first;
      ld_alloc = bus.ld_miss_en && !merge_hit && (st_alloc ? have_second : have_first);
      ld_idx   = st_alloc ? second_free : first_free;
      ld_slot  = wr_ptr_q + {{MSHR_IDX_W{1'b0}}, st_alloc};
   end

   // Next-state: allocations only target FREE entries, issue/return only busy ones
   always_comb begin
      for (int i = 0; i < MSHR_DEPTH; i++)
         state_d[i] = state_q[i];
      if (issue_fire)
         state_d[head_idx] = is_st_q[head_idx] ? E_FREE : E_WAIT_MEM;
      if (ret_hit)
         state_d[ret_idx] = E_FREE;
      if (st_alloc)
         state_d[first_free] = E_WAIT_ISSUE;
      if (ld_alloc)
         state_d[ld_idx] = E_WAIT_ISSUE;
   end

   // State register: entry states, FIFO pointers and registered outputs
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MSHR_DEPTH; i++)
            state_q[i] <= E_FREE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         vld_q       <= 1'b0;
         ld_ack_q    <= 1'b0;
         st_ack_q    <= 1'b0;
         fill_addr_q <= '0;
         fill_data_q <= '0;
      end else begin
         for (int i = 0; i < MSHR_DEPTH; i++)
            state_q[i] <= state_d[i];
         wr_ptr_q <= wr_ptr_q + {{MSHR_IDX_W{1'b0}}, st_alloc} + {{MSHR_IDX_W{1'b0}}, ld_alloc};
         if (issue_fire)
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
         vld_q    <= ret_hit;
         ld_ack_q <= (bus.ld_miss_en && merge_hit) || ld_alloc;
         st_ack_q <= issue_fire && is_st_q[head_idx];
         if (ret_hit) begin
            fill_addr_q <= {blk_q[ret_idx], 3'b000};
            fill_data_q <= bus.mem2proc_data;
         end
      end
   end

   // Entry payload and FIFO slots
   // NOTE: payload arrays are not reset; they are only read while the entry state says valid.
   always_ff @(posedge clk) begin
      if (st_alloc) begin
         is_st_q[first_free]                  <= 1'b1;
         blk_q[first_free]                    <= bus.st_addr[63:3];
         data_q[first_free]                   <= bus.st_data;
         fifo_q[wr_ptr_q[MSHR_IDX_W-1:0]]     <= first_free;
      end
      if (ld_alloc) begin
         is_st_q[ld_idx]                      <= 1'b0;
         blk_q[ld_idx]                        <= ld_blk;
         fifo_q[ld_slot[MSHR_IDX_W-1:0]]      <= ld_idx;
      end
      if (issue_fire && !is_st_q[head_idx])
         tag_q[head_idx] <= bus.mem2proc_response;
   end

   // Outputs: bus request straight from the FIFO head
   always_comb begin
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      if (!fifo_empty) begin
         bus.proc2mem_command = is_st_q[head_idx] ? BUS_STORE : BUS_LOAD;
         bus.proc2mem_addr    = {blk_q[head_idx], 3'b000};
         bus.proc2mem_data    = is_st_q[head_idx] ? data_q[head_idx] : 64'd0;
      end
      bus.mshr_stall  = (free_cnt < ptr_t'(2));
      bus.mshr_vld    = vld_q;
      bus.mshr_addr   = fill_addr_q;
      bus.mshr_data   = fill_data_q;
      bus.mshr_ld_ack = ld_ack_q;
      bus.mshr_st_ack = st_ack_q;
   end

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed bench for dcache_mshr: a timeline table of per-cycle stimulus and
// expected outputs, then a hand-written reset-while-pending sequence.
module tb_dcache_mshr;

   localparam logic [1:0] N = 2'd0;
   localparam logic [1:0] L = 2'd1;
   localparam logic [1:0] S = 2'd2;

   typedef struct {
      logic        ld_en;
      logic [63:0] ld_addr;
      logic        st_en;
      logic [63:0] st_addr;
      logic [63:0] st_data;
      logic [3:0]  resp;
      logic [3:0]  tag;
      logic [63:0] rdata;
      logic [1:0]  cmd;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        stall;
      logic        ld_ack;
      logic        st_ack;
      logic        vld;
      logic [63:0] faddr;
      logic [63:0] fdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   dcache_mshr_if bus_if ();

   dcache_mshr #(.MSHR_DEPTH(4), .MSHR_IDX_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld_en, input logic [63:0] ld_addr,
                        input logic st_en, input logic [63:0] st_addr, input logic [63:0] st_data,
                        input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rdata);
      bus_if.ld_miss_en        = ld_en;
      bus_if.ld_miss_addr      = ld_addr;
      bus_if.st_en             = st_en;
      bus_if.st_addr           = st_addr;
      bus_if.st_data           = st_data;
      bus_if.mem2proc_response = resp;
      bus_if.mem2proc_tag      = tag;
      bus_if.mem2proc_data     = rdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(
      input logic ld_en, input logic [63:0] ld_addr,
      input logic st_en, input logic [63:0] st_addr, input logic [63:0] st_data,
      input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rdata,
      input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] wdata,
      input logic stall, input logic ld_ack, input logic st_ack,
      input logic vld, input logic [63:0] faddr, input logic [63:0] fdata);
      vec_t v;
      v.ld_en = ld_en;  v.ld_addr = ld_addr;
      v.st_en = st_en;  v.st_addr = st_addr;  v.st_data = st_data;
      v.resp  = resp;   v.tag     = tag;      v.rdata   = rdata;
      v.cmd   = cmd;    v.addr    = addr;     v.wdata   = wdata;
      v.stall = stall;  v.ld_ack  = ld_ack;   v.st_ack  = st_ack;
      v.vld   = vld;    v.faddr   = faddr;    v.fdata   = fdata;
      return v;
   endfunction

   initial begin
      //               ld  ld_addr   st st_addr  st_data rsp tag rdata     cmd addr      wdata  stl lak sak vld faddr     fdata
      // Single load miss, fill returns later
      vecs.push_back(mk(1, 64'h1008, 0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  3,  0, 64'h0,    L, 64'h1008, 64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  3, 64'hDEAD, N, 64'h0,    64'h0, 0,  0,  0,  1,  64'h1008, 64'hDEAD));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      // Store rejected twice, then accepted
      vecs.push_back(mk(0, 64'h0,    1, 64'h2000, 64'h5,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    S, 64'h2000, 64'h5, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    S, 64'h2000, 64'h5, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  2,  0, 64'h0,    S, 64'h2000, 64'h5, 0,  0,  1,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      // Second load to the same block merges
      vecs.push_back(mk(1, 64'h3000, 0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(1, 64'h3004, 0, 64'h0,    64'h0,  5,  0, 64'h0,    L, 64'h3000, 64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  5, 64'h33,   N, 64'h0,    64'h0, 0,  0,  0,  1,  64'h3000, 64'h33));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      // Fill all four entries, out-of-order returns, drop while full
      vecs.push_back(mk(1, 64'h4000, 0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(1, 64'h5000, 0, 64'h0,    64'h0,  1,  0, 64'h0,    L, 64'h4000, 64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(1, 64'h6000, 0, 64'h0,    64'h0,  2,  0, 64'h0,    L, 64'h5000, 64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(1, 64'h7000, 0, 64'h0,    64'h0,  3,  0, 64'h0,    L, 64'h6000, 64'h0, 1,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  4,  0, 64'h0,    L, 64'h7000, 64'h0, 1,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(1, 64'h8000, 0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 1,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  4, 64'h44,   N, 64'h0,    64'h0, 1,  0,  0,  1,  64'h7000, 64'h44));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  2, 64'h22,   N, 64'h0,    64'h0, 1,  0,  0,  1,  64'h5000, 64'h22));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  3, 64'h66,   N, 64'h0,    64'h0, 0,  0,  0,  1,  64'h6000, 64'h66));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  1, 64'h11,   N, 64'h0,    64'h0, 0,  0,  0,  1,  64'h4000, 64'h11));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  9, 64'h99,   N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      // Store and load in the same cycle: store goes out first
      vecs.push_back(mk(1, 64'hA000, 1, 64'h9000, 64'h77, 0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  1,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  6,  0, 64'h0,    S, 64'h9000, 64'h77,0,  0,  1,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  7,  0, 64'h0,    L, 64'hA000, 64'h0, 0,  0,  0,  0,  64'h0,    64'h0));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  7, 64'hAA,   N, 64'h0,    64'h0, 0,  0,  0,  1,  64'hA000, 64'hAA));
      vecs.push_back(mk(0, 64'h0,    0, 64'h0,    64'h0,  0,  0, 64'h0,    N, 64'h0,    64'h0, 0,  0,  0,  0,  64'h0,    64'h0));

      // Reset state
      drive(0, 64'h0, 0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      rst = 1'b1;
      tick();
      tick();
      check("reset cmd",       64'(bus_if.proc2mem_command), 64'(N));
      check("reset req addr",  bus_if.proc2mem_addr, 64'h0);
      check("reset stall",     64'(bus_if.mshr_stall), 64'h0);
      check("reset vld",       64'(bus_if.mshr_vld), 64'h0);
      check("reset ld_ack",    64'(bus_if.mshr_ld_ack), 64'h0);
      check("reset st_ack",    64'(bus_if.mshr_st_ack), 64'h0);
      check("reset fill addr", bus_if.mshr_addr, 64'h0);
      check("reset fill data", bus_if.mshr_data, 64'h0);
      rst = 1'b0;

      // Timeline table: inputs held for one cycle, comb outputs checked before the
      // edge, registered outputs checked just after it
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld_en, vecs[i].ld_addr, vecs[i].st_en, vecs[i].st_addr,
               vecs[i].st_data, vecs[i].resp, vecs[i].tag, vecs[i].rdata);
         #1;
         check($sformatf("r%0d cmd", i),   64'(bus_if.proc2mem_command), 64'(vecs[i].cmd));
         check($sformatf("r%0d stall", i), 64'(bus_if.mshr_stall), 64'(vecs[i].stall));
         if (vecs[i].cmd != N)
            check($sformatf("r%0d req addr", i), bus_if.proc2mem_addr, vecs[i].addr);
         if (vecs[i].cmd == S)
            check($sformatf("r%0d req data", i), bus_if.proc2mem_data, vecs[i].wdata);
         tick();
         check($sformatf("r%0d ld_ack", i), 64'(bus_if.mshr_ld_ack), 64'(vecs[i].ld_ack));
         check($sformatf("r%0d st_ack", i), 64'(bus_if.mshr_st_ack), 64'(vecs[i].st_ack));
         check($sformatf("r%0d vld", i),    64'(bus_if.mshr_vld), 64'(vecs[i].vld));
         if (vecs[i].vld) begin
            check($sformatf("r%0d fill addr", i), bus_if.mshr_addr, vecs[i].faddr);
            check($sformatf("r%0d fill data", i), bus_if.mshr_data, vecs[i].fdata);
         end
      end

      // Reset with a load outstanding on tag 2; the late tag must be ignored
      drive(1, 64'hB000, 0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      tick();
      check("rst seq ld_ack", 64'(bus_if.mshr_ld_ack), 64'h1);
      drive(0, 64'h0, 0, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
      #1;
      check("rst seq issue cmd", 64'(bus_if.proc2mem_command), 64'(L));
      tick();
      drive(0, 64'h0, 0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst seq cmd after reset",    64'(bus_if.proc2mem_command), 64'(N));
      check("rst seq stall after reset",  64'(bus_if.mshr_stall), 64'h0);
      check("rst seq ld_ack after reset", 64'(bus_if.mshr_ld_ack), 64'h0);
      drive(0, 64'h0, 0, 64'h0, 64'h0, 4'd0, 4'd2, 64'hBB);
      tick();
      check("rst seq stale tag vld",  64'(bus_if.mshr_vld), 64'h0);
      check("rst seq stale tag data", bus_if.mshr_data, 64'h0);
      // Same block again must allocate fresh and go to the bus (no stale merge)
      drive(1, 64'hB000, 0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      tick();
      check("rst seq realloc ld_ack", 64'(bus_if.mshr_ld_ack), 64'h1);
      drive(0, 64'h0, 0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      #1;
      check("rst seq realloc cmd",  64'(bus_if.proc2mem_command), 64'(L));
      check("rst seq realloc addr", bus_if.proc2mem_addr, 64'hB000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
